// File: rtl/alp_cmd_sequencer.sv
// rtl/alp_cmd_sequencer.sv - command FIFO and issue sequencer driving the ALP strobes
module alp_cmd_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int COMP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    i_CMD,
    input  logic                          i_CMD_VALID,
    output logic                          o_CMD_READY,
    input  logic                          i_ERR,
    input  logic                          i_RESUME,
    output logic [3:0]                    o_DATA_IN,
    output logic [2:0]                    o_OP,
    output logic                          o_CLR,
    output logic                          o_LOAD,
    output logic                          o_COMP,
    output logic [$clog2(FIFO_DEPTH):0]   o_COUNT,
    output logic [6:0]                    o_ISSUED,
    output logic                          o_BUSY,
    output logic                          o_HALT,
    output logic                          o_ILLEGAL
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int HOLD_W = $clog2(COMP_CYCLES) + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_COMP_HOLD = 2'd2;
    localparam logic [1:0] S_HALT      = 2'd3;

    logic [9:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              avail_q, avail_d;
    logic              rdy_en_q, rdy_en_d;

    logic [1:0]        state_q, state_d;
    logic [9:0]        cmd_q, cmd_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [6:0]        issued_q, issued_d;
    logic              illegal_q, illegal_d;

    logic              push;
    logic              pop;
    logic              launch;
    logic [9:0]        head;
    logic              head_legal;

    assign head       = mem_q[rd_ptr_q];
    assign head_legal = (head[2:0] == 3'b001) || (head[2:0] == 3'b010) || (head[2:0] == 3'b100);

    // Ready is held off until the first edge after reset so nothing lands mid-release.
    assign o_CMD_READY = rdy_en_q && (count_q != CNT_W'(FIFO_DEPTH));

    // FIFO bookkeeping: pointers wrap at the depth, count tracks push minus pop.
    always_comb begin
        push     = i_CMD_VALID && o_CMD_READY;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        // IDLE only launches a head that has been resident for a full cycle.
        avail_d  = (count_q != '0);
        rdy_en_d = 1'b1;
    end

    // Sequencer: launch, hold compute strobes, halt on compute error, discard malformed heads.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        hold_d    = hold_q;
        issued_d  = issued_q;
        illegal_d = illegal_q;
        pop       = 1'b0;
        launch    = 1'b0;
        case (state_q)
            S_IDLE: begin
                launch = avail_q;
            end
            S_ISSUE, S_COMP_HOLD: begin
                if (hold_q != '0) begin
                    state_d = S_COMP_HOLD;
                    hold_d  = hold_q - HOLD_W'(1);
                end else if (cmd_q[0] && i_ERR) begin
                    state_d = S_HALT;
                    cmd_d   = '0;
                end else begin
                    launch = 1'b1;
                end
            end
            S_HALT: begin
                if (i_RESUME) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cmd_d   = '0;
            end
        endcase
        if (launch) begin
            if (count_q == '0) begin
                state_d = S_IDLE;
                cmd_d   = '0;
            end else begin
                pop = 1'b1;
                if (head_legal) begin
                    state_d  = S_ISSUE;
                    cmd_d    = head;
                    issued_d = issued_q + 7'd1;
                    hold_d   = head[0] ? HOLD_W'(COMP_CYCLES - 1) : '0;
                end else begin
                    state_d   = S_IDLE;
                    cmd_d     = '0;
                    illegal_d = 1'b1;
                end
            end
        end
    end

    // Command storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_CMD;
        end
    end

    // State registers; reset drops everything buffered or in flight at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            avail_q   <= 1'b0;
            rdy_en_q  <= 1'b0;
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            hold_q    <= '0;
            issued_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            avail_q   <= avail_d;
            rdy_en_q  <= rdy_en_d;
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            hold_q    <= hold_d;
            issued_q  <= issued_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_DATA_IN = cmd_q[9:6];
    assign o_OP      = cmd_q[5:3];
    assign o_CLR     = cmd_q[2];
    assign o_LOAD    = cmd_q[1];
    assign o_COMP    = cmd_q[0];
    assign o_COUNT   = count_q;
    assign o_ISSUED  = issued_q;
    assign o_BUSY    = (state_q == S_ISSUE) || (state_q == S_COMP_HOLD);
    assign o_HALT    = (state_q == S_HALT);
    assign o_ILLEGAL = illegal_q;

endmodule
